// File: rtl/mem_wb_skid_reg_pkg.sv
// Shared pipeline definitions for the MEM/WB skid register: default widths,
// control state encoding and the occupancy mapping derived from it.
package mem_wb_skid_reg_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEST_W_DEF = 5;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    function automatic logic [1:0] occ_of(input skid_state_e s);
        logic [1:0] occ;
        occ = OCC_EMPTY;
        case (s)
            ST_ONE:  occ = OCC_ONE;
            ST_FULL: occ = OCC_FULL;
            default: occ = OCC_EMPTY;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/mem_wb_skid_reg_pipe_reg.sv
// Generic enabled storage register with asynchronous clear; one instance
// holds one payload field of one skid-buffer entry.
module mem_wb_skid_reg_pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_wb_skid_reg.sv
// MEM/WB pipeline register with a two-entry skid buffer: entry 0 (main)
// drives the WB stage, entry 1 (skid) absorbs one beat of backpressure.
module mem_wb_skid_reg
    import mem_wb_skid_reg_pkg::*;
#(
    parameter int DATA_W          = DATA_W_DEF,
    parameter int DEST_W          = DEST_W_DEF,
    parameter bit FLUSH_KEEP_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] PC_in,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic [DATA_W-1:0] MEM_R_value_in,
    input  logic [DEST_W-1:0] Dest_in,
    input  logic              MEM_R_en_in,
    input  logic              WB_en_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] PC,
    output logic [DATA_W-1:0] ALU_result,
    output logic [DATA_W-1:0] MEM_R_value,
    output logic [DEST_W-1:0] Dest,
    output logic              MEM_R_en,
    output logic              WB_en,
    output logic [1:0]        occupancy
);

    skid_state_e state_reg, state_next;
    logic        in_ready_reg;
    logic        main_valid, xfer_in, xfer_out;
    logic        main_load, main_from_skid, skid_load;

    // Index 0 = main entry, index 1 = skid entry.
    logic [DATA_W-1:0] pc_d [2], pc_q [2];
    logic [DATA_W-1:0] alu_d [2], alu_q [2];
    logic [DATA_W-1:0] memv_d [2], memv_q [2];
    logic [DEST_W-1:0] dest_d [2], dest_q [2];
    logic              mren_d [2], mren_q [2];
    logic              wben_d [2], wben_q [2];
    logic              data_en [2], ctrl_en [2];

    assign main_valid = (state_reg != ST_EMPTY);
    assign xfer_in    = in_valid && in_ready_reg;
    assign xfer_out   = main_valid && out_ready;

    // in_ready comes from a flop fed by the next state, so out_ready never
    // reaches it combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_EMPTY;
            in_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != ST_FULL);
        end
    end

    always_comb begin
        state_next     = state_reg;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state_reg)
            ST_EMPTY: begin
                if (xfer_in) begin
                    state_next = ST_ONE;
                    main_load  = 1'b1;
                end
            end
            ST_ONE: begin
                if (xfer_in && xfer_out) begin
                    main_load = 1'b1;
                end else if (xfer_in) begin
                    state_next = ST_FULL;
                    skid_load  = 1'b1;
                end else if (xfer_out) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (xfer_out) begin
                    state_next     = ST_ONE;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
        if (flush) begin
            state_next     = ST_EMPTY;
            main_load      = 1'b0;
            main_from_skid = 1'b0;
            skid_load      = 1'b0;
        end
    end

    // Flush always clears control bits; data fields are wiped only when not kept.
    always_comb begin
        data_en[0] = main_load || (flush && !FLUSH_KEEP_DATA);
        data_en[1] = skid_load || (flush && !FLUSH_KEEP_DATA);
        ctrl_en[0] = main_load || flush;
        ctrl_en[1] = skid_load || flush;
        if (flush) begin
            pc_d[0] = '0; alu_d[0] = '0; memv_d[0] = '0; dest_d[0] = '0;
            mren_d[0] = 1'b0; wben_d[0] = 1'b0;
        end else if (main_from_skid) begin
            pc_d[0] = pc_q[1]; alu_d[0] = alu_q[1]; memv_d[0] = memv_q[1];
            dest_d[0] = dest_q[1]; mren_d[0] = mren_q[1]; wben_d[0] = wben_q[1];
        end else begin
            pc_d[0] = PC_in; alu_d[0] = ALU_result_in; memv_d[0] = MEM_R_value_in;
            dest_d[0] = Dest_in; mren_d[0] = MEM_R_en_in; wben_d[0] = WB_en_in;
        end
        pc_d[1]   = flush ? '0 : PC_in;
        alu_d[1]  = flush ? '0 : ALU_result_in;
        memv_d[1] = flush ? '0 : MEM_R_value_in;
        dest_d[1] = flush ? '0 : Dest_in;
        mren_d[1] = flush ? 1'b0 : MEM_R_en_in;
        wben_d[1] = flush ? 1'b0 : WB_en_in;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        mem_wb_skid_reg_pipe_reg #(.W(DATA_W)) u_pc (
            .clk(clk), .rst(rst), .enable(data_en[gi]), .d(pc_d[gi]), .q(pc_q[gi]));
        mem_wb_skid_reg_pipe_reg #(.W(DATA_W)) u_alu (
            .clk(clk), .rst(rst), .enable(data_en[gi]), .d(alu_d[gi]), .q(alu_q[gi]));
        mem_wb_skid_reg_pipe_reg #(.W(DATA_W)) u_memv (
            .clk(clk), .rst(rst), .enable(data_en[gi]), .d(memv_d[gi]), .q(memv_q[gi]));
        mem_wb_skid_reg_pipe_reg #(.W(DEST_W)) u_dest (
            .clk(clk), .rst(rst), .enable(data_en[gi]), .d(dest_d[gi]), .q(dest_q[gi]));
        mem_wb_skid_reg_pipe_reg #(.W(1)) u_mren (
            .clk(clk), .rst(rst), .enable(ctrl_en[gi]), .d(mren_d[gi]), .q(mren_q[gi]));
        mem_wb_skid_reg_pipe_reg #(.W(1)) u_wben (
            .clk(clk), .rst(rst), .enable(ctrl_en[gi]), .d(wben_d[gi]), .q(wben_q[gi]));
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = main_valid;
    assign occupancy   = occ_of(state_reg);
    assign PC          = pc_q[0];
    assign ALU_result  = alu_q[0];
    assign MEM_R_value = memv_q[0];
    assign Dest        = dest_q[0];
    // A bubble must never request a register-file write or a memory read.
    assign MEM_R_en    = mren_q[0] && main_valid;
    assign WB_en       = wben_q[0] && main_valid;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Scoreboard bench for mem_wb_skid_reg: an ideal two-deep FIFO model tracks
// accepted entries; a negedge monitor compares every DUT output against it.
module tb_mem_wb_skid_reg;

    localparam int DW = 64;
    localparam int EW = 6;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic          in_ready, out_valid;
    logic [DW-1:0] pc_in, alu_in, memv_in;
    logic [EW-1:0] dest_in;
    logic          mren_in, wben_in;
    logic [DW-1:0] pc_o, alu_o, memv_o;
    logic [EW-1:0] dest_o;
    logic          mren_o, wben_o;
    logic [1:0]    occupancy;

    typedef struct packed {
        logic [DW-1:0] pc;
        logic [DW-1:0] alu;
        logic [DW-1:0] memv;
        logic [EW-1:0] dest;
        logic          mren;
        logic          wben;
    } ent_t;

    ent_t q[$];
    bit   zero_known = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mem_wb_skid_reg #(.DATA_W(DW), .DEST_W(EW), .FLUSH_KEEP_DATA(1'b0)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .PC_in(pc_in), .ALU_result_in(alu_in), .MEM_R_value_in(memv_in),
        .Dest_in(dest_in), .MEM_R_en_in(mren_in), .WB_en_in(wben_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .PC(pc_o), .ALU_result(alu_o), .MEM_R_value(memv_o), .Dest(dest_o),
        .MEM_R_en(mren_o), .WB_en(wben_o), .occupancy(occupancy)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a FIFO of capacity two; flush/reset empty it.
    always @(posedge rst) begin
        q.delete();
        zero_known = 1'b1;
    end

    always @(posedge clk) begin
        if (rst || flush) begin
            q.delete();
            zero_known = 1'b1;
        end else begin
            bit do_out, do_in;
            do_out = (q.size() > 0) && out_ready;
            do_in  = in_valid && (q.size() < 2);
            if (do_out) void'(q.pop_front());
            if (do_in) begin
                q.push_back('{pc: pc_in, alu: alu_in, memv: memv_in, dest: dest_in,
                              mren: mren_in, wben: wben_in});
                zero_known = 1'b0;
            end
        end
    end

    task automatic check_outputs();
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        chk("occupancy", occupancy, q.size());
        if (q.size() > 0) begin
            chk("PC", pc_o, q[0].pc);
            chk("ALU_result", alu_o, q[0].alu);
            chk("MEM_R_value", memv_o, q[0].memv);
            chk("Dest", dest_o, q[0].dest);
            chk("MEM_R_en", mren_o, q[0].mren);
            chk("WB_en", wben_o, q[0].wben);
        end else begin
            chk("bubble_MEM_R_en", mren_o, 1'b0);
            chk("bubble_WB_en", wben_o, 1'b0);
            if (zero_known) begin
                chk("zero_PC", pc_o, '0);
                chk("zero_ALU_result", alu_o, '0);
                chk("zero_MEM_R_value", memv_o, '0);
                chk("zero_Dest", dest_o, '0);
            end
        end
    endtask

    always @(negedge clk) check_outputs();

    task automatic send(input bit v, input logic [DW-1:0] pc, input logic [DW-1:0] alu,
                        input logic [EW-1:0] dest, input bit wb);
        @(negedge clk);
        in_valid = v;
        pc_in    = pc;
        alu_in   = alu;
        memv_in  = pc ^ alu;
        dest_in  = dest;
        wben_in  = wb;
        mren_in  = ~wb;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        pc_in = '0; alu_in = '0; memv_in = '0; dest_in = '0; mren_in = 1'b0; wben_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Streaming
        out_ready = 1'b1;
        send(1, 64'h100, 64'h1, 6'd1, 1);
        send(1, 64'h104, 64'h2, 6'd2, 1);
        send(1, 64'h108, 64'h3, 6'd3, 0);
        send(0, '0, '0, '0, 0);
        repeat (2) @(negedge clk);

        // Backpressure, then release with re-send of the rejected entry
        out_ready = 1'b0;
        send(1, 64'h200, 64'hA, 6'd4, 1);
        send(1, 64'h204, 64'hB, 6'd5, 1);
        send(1, 64'h208, 64'hC, 6'd6, 1);
        send(0, '0, '0, '0, 0);
        out_ready = 1'b1;
        send(1, 64'h208, 64'hC, 6'd6, 1);
        send(0, '0, '0, '0, 0);
        repeat (2) @(negedge clk);

        // Flush priority from FULL
        out_ready = 1'b0;
        send(1, 64'h300, 64'h11, 6'd7, 1);
        send(1, 64'h304, 64'h12, 6'd8, 1);
        send(1, 64'h308, 64'h13, 6'd9, 1);
        out_ready = 1'b1;
        flush = 1'b1;
        send(0, '0, '0, '0, 0);
        flush = 1'b0;
        repeat (2) @(negedge clk);

        // Bubble with live-looking control inputs
        send(0, 64'h400, 64'h21, 6'd31, 1);
        repeat (2) @(negedge clk);

        // Wide payload held under backpressure
        out_ready = 1'b0;
        send(1, 64'h500, 64'hDEAD_BEEF_0000_0001, 6'd63, 1);
        send(0, '0, '0, '0, 0);
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a FULL state
        out_ready = 1'b0;
        send(1, 64'h600, 64'h31, 6'd10, 1);
        send(1, 64'h604, 64'h32, 6'd11, 1);
        send(0, '0, '0, '0, 0);
        #2 rst = 1'b1;
        #1 check_outputs();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            pc_in     = {$urandom, $urandom};
            alu_in    = {$urandom, $urandom};
            memv_in   = {$urandom, $urandom};
            dest_in   = EW'($urandom);
            mren_in   = 1'($urandom);
            wben_in   = 1'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("drained_occupancy", occupancy, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
